// File: rtl/apb_pkg.sv
// Shared APB definitions: bridge state encoding, request/response record
// types and the default peripheral window used by the bridge and by slaves
// such as the APB UART.
package apb_pkg;

  localparam int unsigned APB_AW = 32;
  localparam int unsigned APB_DW = 32;

  localparam logic [APB_AW-1:0] APB_WIN_BASE = 32'h1000_0000;
  localparam logic [APB_AW-1:0] APB_WIN_MASK = 32'hF000_0000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

  typedef struct packed {
    logic              write;
    logic [APB_AW-1:0] addr;
    logic [APB_DW-1:0] wdata;
  } apb_req_t;

  typedef struct packed {
    logic [APB_DW-1:0] rdata;
    logic              err;
    logic              timeout;
  } apb_rsp_t;

endpackage

// File: rtl/apb_master_bridge_if.sv
// Bundle of the requester-side valid/ready port and the APB3 bus.
// master : view of the bridge (drives req_ready, rsp_*, P* outputs)
// slave  : view of the environment (requester plus APB slave)
interface apb_master_bridge_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  logic                  rsp_timeout;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
           PRDATA, PREADY, PSLVERR,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
           PADDR, PSEL, PENABLE, PWRITE, PWDATA
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
           PRDATA, PREADY, PSLVERR,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
           PADDR, PSEL, PENABLE, PWRITE, PWDATA
  );
endinterface

// File: rtl/apb_timeout_counter.sv
// Saturating ACCESS-phase stall counter.
// PCLK, PRESETn : clock, synchronous active-low reset
// clear         : return count to zero (has priority over enable)
// enable        : count one stalled cycle
// terminal      : count equals LIMIT-1; never asserted when LIMIT is 0
module apb_timeout_counter #(
  parameter int unsigned LIMIT = 256,
  parameter int unsigned WIDTH = 9
) (
  input  logic PCLK,
  input  logic PRESETn,
  input  logic clear,
  input  logic enable,
  output logic terminal
);
  // A zero-width counter is not legal; LIMIT==0 still needs one bit.
  localparam int unsigned CW = (WIDTH < 1) ? 1 : WIDTH;
  localparam logic [CW-1:0] TERM = (LIMIT == 0) ? '0 : CW'(LIMIT - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge PCLK) begin
    if (!PRESETn || clear) begin
      cnt_q <= '0;
    end else if (enable && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign terminal = (LIMIT != 0) && (cnt_q == TERM);

endmodule

// File: rtl/apb_master_bridge.sv
// Single-outstanding APB3 initiator. Accepts one valid/ready request,
// decodes it against one address window, runs SETUP/ACCESS on APB (or
// answers a decode error locally), and returns one response.
// PCLK, PRESETn : clock, synchronous active-low reset
// bus (master)  : req_* / rsp_* requester port and the APB3 P* signals
// All outputs are registered.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH     = 32,
  parameter int unsigned           DATA_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0] WIN_BASE       = ADDR_WIDTH'(APB_WIN_BASE),
  parameter logic [ADDR_WIDTH-1:0] WIN_MASK       = ADDR_WIDTH'(APB_WIN_MASK),
  parameter int unsigned           TIMEOUT_CYCLES = 256,
  parameter int unsigned           TO_CNT_WIDTH   = $clog2(TIMEOUT_CYCLES + 1)
) (
  input logic               PCLK,
  input logic               PRESETn,
  apb_master_bridge_if.master bus
);

  apb_state_e state_q, state_d;

  logic                  req_ready_q,   req_ready_d;
  logic                  rsp_valid_q,   rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q,   rsp_rdata_d;
  logic                  rsp_err_q,     rsp_err_d;
  logic                  rsp_timeout_q, rsp_timeout_d;
  logic [ADDR_WIDTH-1:0] paddr_q,       paddr_d;
  logic                  psel_q,        psel_d;
  logic                  penable_q,     penable_d;
  logic                  pwrite_q,      pwrite_d;
  logic [DATA_WIDTH-1:0] pwdata_q,      pwdata_d;

  logic to_terminal;

  // Counter is held at zero outside ACCESS, so it restarts on every entry.
  apb_timeout_counter #(
    .LIMIT (TIMEOUT_CYCLES),
    .WIDTH (TO_CNT_WIDTH)
  ) u_timeout (
    .PCLK     (PCLK),
    .PRESETn  (PRESETn),
    .clear    (state_q != ACCESS),
    .enable   ((state_q == ACCESS) && !bus.PREADY),
    .terminal (to_terminal)
  );

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_q       <= IDLE;
      req_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      paddr_q       <= '0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      pwdata_q      <= '0;
    end else begin
      state_q       <= state_d;
      req_ready_q   <= req_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
      paddr_q       <= paddr_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      pwdata_q      <= pwdata_d;
    end
  end

  // Next values of the registered outputs, one cycle ahead of the bus.
  always_comb begin
    state_d       = state_q;
    req_ready_d   = req_ready_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    paddr_d       = paddr_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    pwrite_d      = pwrite_q;
    pwdata_d      = pwdata_q;

    unique case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        if (bus.req_valid && req_ready_q) begin
          req_ready_d = 1'b0;
          if ((bus.req_addr & WIN_MASK) == WIN_BASE) begin
            paddr_d  = bus.req_addr;
            pwrite_d = bus.req_write;
            pwdata_d = bus.req_wdata;
            psel_d   = 1'b1;
            state_d  = SETUP;
          end else begin
            rsp_valid_d   = 1'b1;
            rsp_err_d     = 1'b1;
            rsp_timeout_d = 1'b0;
            rsp_rdata_d   = '0;
            state_d       = RESP;
          end
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
      end
      ACCESS: begin
        // PREADY is tested first so a completion on the timeout edge wins.
        if (bus.PREADY) begin
          rsp_rdata_d   = pwrite_q ? '0 : bus.PRDATA;
          rsp_err_d     = bus.PSLVERR;
          rsp_timeout_d = 1'b0;
          rsp_valid_d   = 1'b1;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          state_d       = RESP;
        end else if (to_terminal) begin
          rsp_rdata_d   = '0;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_valid_d   = 1'b1;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          state_d       = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.req_ready   = req_ready_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_timeout = rsp_timeout_q;
  assign bus.PADDR       = paddr_q;
  assign bus.PSEL        = psel_q;
  assign bus.PENABLE     = penable_q;
  assign bus.PWRITE      = pwrite_q;
  assign bus.PWDATA      = pwdata_q;

endmodule
